// File: rtl/axis_bram_adapter_if.sv
// rtl/axis_bram_adapter_if.sv - stream and AXI-Lite bundle for axis_bram_adapter
// slave modport is the adapter's view; master is the DMA/CPU side.
interface axis_bram_adapter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int C_S_AXI_ADDR_W = 5
);
  logic [DATA_WIDTH-1:0]     s00_axis_tdata;
  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb;
  logic                      s00_axis_tlast;
  logic                      s00_axis_tvalid;
  logic                      s00_axis_tready;

  logic [DATA_WIDTH-1:0]     m00_axis_tdata;
  logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb;
  logic                      m00_axis_tlast;
  logic                      m00_axis_tvalid;
  logic                      m00_axis_tready;

  logic [C_S_AXI_ADDR_W-1:0] s02_axi_awaddr;
  logic [2:0]                s02_axi_awprot;
  logic                      s02_axi_awvalid;
  logic                      s02_axi_awready;
  logic [31:0]               s02_axi_wdata;
  logic [3:0]                s02_axi_wstrb;
  logic                      s02_axi_wvalid;
  logic                      s02_axi_wready;
  logic [1:0]                s02_axi_bresp;
  logic                      s02_axi_bvalid;
  logic                      s02_axi_bready;
  logic [C_S_AXI_ADDR_W-1:0] s02_axi_araddr;
  logic [2:0]                s02_axi_arprot;
  logic                      s02_axi_arvalid;
  logic                      s02_axi_arready;
  logic [31:0]               s02_axi_rdata;
  logic [1:0]                s02_axi_rresp;
  logic                      s02_axi_rvalid;
  logic                      s02_axi_rready;

  modport slave (
    input  s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tvalid,
    output s00_axis_tready,
    output m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tvalid,
    input  m00_axis_tready,
    input  s02_axi_awaddr, s02_axi_awprot, s02_axi_awvalid,
    output s02_axi_awready,
    input  s02_axi_wdata, s02_axi_wstrb, s02_axi_wvalid,
    output s02_axi_wready,
    output s02_axi_bresp, s02_axi_bvalid,
    input  s02_axi_bready,
    input  s02_axi_araddr, s02_axi_arprot, s02_axi_arvalid,
    output s02_axi_arready,
    output s02_axi_rdata, s02_axi_rresp, s02_axi_rvalid,
    input  s02_axi_rready
  );

  modport master (
    output s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tvalid,
    input  s00_axis_tready,
    input  m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tvalid,
    output m00_axis_tready,
    output s02_axi_awaddr, s02_axi_awprot, s02_axi_awvalid,
    input  s02_axi_awready,
    output s02_axi_wdata, s02_axi_wstrb, s02_axi_wvalid,
    input  s02_axi_wready,
    input  s02_axi_bresp, s02_axi_bvalid,
    output s02_axi_bready,
    output s02_axi_araddr, s02_axi_arprot, s02_axi_arvalid,
    input  s02_axi_arready,
    input  s02_axi_rdata, s02_axi_rresp, s02_axi_rvalid,
    output s02_axi_rready
  );
endinterface

// File: rtl/axis_bram_adapter.sv
// rtl/axis_bram_adapter.sv - 32-bit AXI-Stream <-> 1152-bit BRAM line adapter with AXI-Lite control
// Optional AXIS_BRAM_STATUS_EN builds the STATUS register at 0x0C (reads 0 otherwise).
module axis_bram_adapter #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_LINE  = 36,
  parameter int BRAM_ADDR_WIDTH = 12,
  parameter int C_S_AXI_ADDR_W  = 5
) (
  input  logic                                 s00_axis_aclk,
  input  logic                                 s00_axis_aresetn,
  axis_bram_adapter_if.slave                   bus,
  output logic                                 BRAM_CLK,
  output logic                                 BRAM_EN,
  output logic                                 BRAM_WEN,
  output logic [BRAM_ADDR_WIDTH-1:0]           BRAM_ADDR,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] BRAM_IN,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] BRAM_OUT
);
  localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
  localparam int KW     = $clog2(WORDS_PER_LINE);
  localparam int PW     = $clog2(LINE_W);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS_PER_LINE - 1);
  localparam logic [KW-1:0] K_PEN  = KW'(WORDS_PER_LINE - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_COMMIT, S_FETCH, S_WAIT, S_STREAM, S_DONE
  } state_t;

  state_t                     r_state;
  logic [1:0]                 r_ctrl;
  logic [BRAM_ADDR_WIDTH-1:0] r_start, r_end, r_cur, r_addr;
  logic [LINE_W-1:0]          r_line;
  logic [KW-1:0]              r_k;
  logic                       r_last_seen;
  logic                       r_s_tready, r_m_tvalid, r_m_tlast, r_en, r_wen;
  logic                       r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [31:0]                r_rdata;

  logic [2:0]                 w_wr_sel, w_rd_sel;
  logic                       w_wr_en, w_ctrl_wr, w_reload, w_arm;
  logic [1:0]                 w_ctrl_new;
  logic [PW-1:0]              w_wr_pos;
  logic [31:0]                w_rd_mux;
  logic                       w_unused;

  function automatic logic [BRAM_ADDR_WIDTH-1:0] f_merge(
    input logic [BRAM_ADDR_WIDTH-1:0] old_v,
    input logic [31:0]                d,
    input logic [3:0]                 s
  );
    f_merge = old_v;
    for (int i = 0; i < BRAM_ADDR_WIDTH; i++)
      if (s[i/8]) f_merge[i] = d[i];
  endfunction

  assign w_wr_sel   = bus.s02_axi_awaddr[4:2];
  assign w_rd_sel   = bus.s02_axi_araddr[4:2];
  assign w_wr_en    = r_awready && bus.s02_axi_awvalid && bus.s02_axi_wvalid;
  assign w_ctrl_wr  = w_wr_en && (w_wr_sel == 3'd0);
  assign w_ctrl_new = bus.s02_axi_wstrb[0] ? bus.s02_axi_wdata[1:0] : r_ctrl;
  // A session is armed only on the falling edge of RELOAD, never by a plain RW rewrite.
  assign w_reload   = w_ctrl_wr && w_ctrl_new[1];
  assign w_arm      = w_ctrl_wr && r_ctrl[1] && !w_ctrl_new[1];
  assign w_wr_pos   = PW'(r_k) * PW'(DATA_WIDTH);

  assign w_unused = &{1'b0, bus.s02_axi_awaddr[1:0], bus.s02_axi_araddr[1:0],
                      bus.s02_axi_awprot, bus.s02_axi_arprot, bus.s00_axis_tstrb,
                      bus.s02_axi_wstrb[3:2], bus.s02_axi_wdata[31:BRAM_ADDR_WIDTH]};

`ifdef AXIS_BRAM_STATUS_EN
  logic w_busy, w_done;
  assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_done = (r_state == S_DONE);
`endif

  always_comb begin
    w_rd_mux = '0;
    case (w_rd_sel)
      3'd0: w_rd_mux = {30'b0, r_ctrl};
      3'd1: w_rd_mux = {{(32-BRAM_ADDR_WIDTH){1'b0}}, r_start};
      3'd2: w_rd_mux = {{(32-BRAM_ADDR_WIDTH){1'b0}}, r_end};
`ifdef AXIS_BRAM_STATUS_EN
      3'd3: w_rd_mux = {16'b0, w_busy, w_done, 2'b0, r_cur};
`endif
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_ctrl    <= '0;
      r_start   <= '0;
      r_end     <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      if (bus.s02_axi_awvalid && bus.s02_axi_wvalid && !r_awready && !r_bvalid) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        case (w_wr_sel)
          3'd0:    r_ctrl  <= w_ctrl_new;
          3'd1:    r_start <= f_merge(r_start, bus.s02_axi_wdata, bus.s02_axi_wstrb);
          3'd2:    r_end   <= f_merge(r_end, bus.s02_axi_wdata, bus.s02_axi_wstrb);
          default: ;
        endcase
      end else if (r_bvalid && bus.s02_axi_bready) begin
        r_bvalid <= 1'b0;
      end

      r_arready <= 1'b0;
      if (bus.s02_axi_arvalid && !r_arready && !r_rvalid) r_arready <= 1'b1;
      if (r_arready && bus.s02_axi_arvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (r_rvalid && bus.s02_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_addr      <= '0;
      r_line      <= '0;
      r_k         <= '0;
      r_last_seen <= 1'b0;
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_en        <= 1'b0;
      r_wen       <= 1'b0;
    end else if (w_reload) begin
      r_state     <= S_IDLE;
      r_cur       <= r_start;
      r_line      <= '0;
      r_k         <= '0;
      r_last_seen <= 1'b0;
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_en        <= 1'b0;
      r_wen       <= 1'b0;
    end else if (w_arm) begin
      r_cur       <= r_start;
      r_line      <= '0;
      r_k         <= '0;
      r_last_seen <= 1'b0;
      if (r_end < r_start) begin
        r_state <= S_DONE;
      end else if (w_ctrl_new[0]) begin
        r_state    <= S_COLLECT;
        r_s_tready <= 1'b1;
      end else begin
        r_state <= S_FETCH;
        r_en    <= 1'b1;
        r_wen   <= 1'b0;
        r_addr  <= r_start;
      end
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (bus.s00_axis_tvalid) begin
            r_line[w_wr_pos +: DATA_WIDTH] <= bus.s00_axis_tdata;
            // Line was cleared on entry, so an early tlast leaves the tail zero-filled.
            if (r_k == K_LAST || bus.s00_axis_tlast) begin
              r_s_tready  <= 1'b0;
              r_en        <= 1'b1;
              r_wen       <= 1'b1;
              r_addr      <= r_cur;
              r_last_seen <= bus.s00_axis_tlast;
              r_state     <= S_COMMIT;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          r_en   <= 1'b0;
          r_wen  <= 1'b0;
          r_line <= '0;
          r_k    <= '0;
          if (r_cur == r_end || r_last_seen) begin
            r_state <= S_DONE;
          end else begin
            r_cur      <= r_cur + 1'b1;
            r_s_tready <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_FETCH: begin
          r_en    <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_line     <= BRAM_OUT;
          r_k        <= '0;
          r_m_tvalid <= 1'b1;
          r_m_tlast  <= (WORDS_PER_LINE == 1) && (r_cur == r_end);
          r_state    <= S_STREAM;
        end
        S_STREAM: begin
          if (bus.m00_axis_tready) begin
            if (r_k == K_LAST) begin
              r_m_tvalid <= 1'b0;
              r_m_tlast  <= 1'b0;
              if (r_cur == r_end) begin
                r_state <= S_DONE;
              end else begin
                r_cur   <= r_cur + 1'b1;
                r_addr  <= r_cur + 1'b1;
                r_en    <= 1'b1;
                r_state <= S_FETCH;
              end
            end else begin
              r_line    <= {{DATA_WIDTH{1'b0}}, r_line[LINE_W-1:DATA_WIDTH]};
              r_k       <= r_k + 1'b1;
              r_m_tlast <= (r_k == K_PEN) && (r_cur == r_end);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign BRAM_CLK  = s00_axis_aclk;
  assign BRAM_EN   = r_en;
  assign BRAM_WEN  = r_wen;
  assign BRAM_ADDR = r_addr;
  assign BRAM_IN   = r_line;

  assign bus.s00_axis_tready = r_s_tready;
  assign bus.m00_axis_tdata  = r_line[DATA_WIDTH-1:0];
  assign bus.m00_axis_tstrb  = '1;
  assign bus.m00_axis_tlast  = r_m_tlast;
  assign bus.m00_axis_tvalid = r_m_tvalid;
  assign bus.s02_axi_awready = r_awready;
  assign bus.s02_axi_wready  = r_wready;
  assign bus.s02_axi_bresp   = 2'b00;
  assign bus.s02_axi_bvalid  = r_bvalid;
  assign bus.s02_axi_arready = r_arready;
  assign bus.s02_axi_rdata   = r_rdata;
  assign bus.s02_axi_rresp   = 2'b00;
  assign bus.s02_axi_rvalid  = r_rvalid;
endmodule

// File: tb/tb_axis_bram_adapter.sv
// tb/tb_axis_bram_adapter.sv - bench for axis_bram_adapter
// Line-level model of expected BRAM writes and stream beats, checked every cycle.
module tb_axis_bram_adapter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_bram_adapter_if #(.DATA_WIDTH(32), .C_S_AXI_ADDR_W(5)) bus();

  logic          bram_clk, bram_en, bram_wen;
  logic [11:0]   bram_addr;
  logic [1151:0] bram_in, bram_dout;
  logic [1151:0] bram [16];
  logic [1151:0] mdl_mem [16];

  axis_bram_adapter dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .bus(bus),
    .BRAM_CLK(bram_clk), .BRAM_EN(bram_en), .BRAM_WEN(bram_wen),
    .BRAM_ADDR(bram_addr), .BRAM_IN(bram_in), .BRAM_OUT(bram_dout)
  );

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_wen) bram[bram_addr[3:0]] <= bram_in;
      else          bram_dout <= bram[bram_addr[3:0]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int n_beats  = 0;
  int n_tlasts = 0;

  logic [11:0]   exp_waddr[$];
  logic [1151:0] exp_wdata[$];
  logic [32:0]   exp_beats[$];
  logic [31:0]   tx_data[$];
  logic          tx_last[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL timeout %s", name);
  endtask

  // Reference behaviour: pack words 36 per line from START, stop at END or tlast.
  task automatic model_write(input logic [11:0] st, input logic [11:0] en);
    logic [1151:0] line;
    logic [11:0]   a;
    int            k;
    line = '0; a = st; k = 0;
    for (int i = 0; i < tx_data.size(); i++) begin
      line[k*32 +: 32] = tx_data[i];
      k++;
      if (k == 36 || tx_last[i]) begin
        exp_waddr.push_back(a);
        exp_wdata.push_back(line);
        mdl_mem[a[3:0]] = line;
        if (a == en || tx_last[i]) break;
        a++; line = '0; k = 0;
      end
    end
  endtask

  task automatic model_read(input logic [11:0] st, input logic [11:0] en);
    logic [1151:0] line;
    for (int a = int'(st); a <= int'(en); a++) begin
      line = mdl_mem[a[3:0]];
      for (int k = 0; k < 36; k++)
        exp_beats.push_back({(a == int'(en)) && (k == 35), line[k*32 +: 32]});
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    bus.s02_axi_awaddr = a; bus.s02_axi_awvalid = 1'b1;
    bus.s02_axi_wdata = d; bus.s02_axi_wstrb = 4'hF; bus.s02_axi_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.s02_axi_awready && n < 50);
    if (!bus.s02_axi_awready) timeout_fail("awready");
    chk("wready_with_awready", {31'b0, bus.s02_axi_wready}, 32'd1);
    @(posedge clk); #1;
    bus.s02_axi_awvalid = 1'b0; bus.s02_axi_wvalid = 1'b0; bus.s02_axi_bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.s02_axi_bvalid && n < 50);
    if (!bus.s02_axi_bvalid) timeout_fail("bvalid");
    chk("bresp", {30'b0, bus.s02_axi_bresp}, 32'd0);
    @(posedge clk); #1;
    bus.s02_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    bus.s02_axi_araddr = a; bus.s02_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.s02_axi_arready && n < 50);
    if (!bus.s02_axi_arready) timeout_fail("arready");
    @(posedge clk); #1;
    bus.s02_axi_arvalid = 1'b0; bus.s02_axi_rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.s02_axi_rvalid && n < 50);
    if (!bus.s02_axi_rvalid) timeout_fail("rvalid");
    d = bus.s02_axi_rdata;
    @(posedge clk); #1;
    bus.s02_axi_rready = 1'b0;
  endtask

  task automatic send_stream();
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < tx_data.size(); i++) begin
      bus.s00_axis_tdata = tx_data[i];
      bus.s00_axis_tlast = tx_last[i];
      bus.s00_axis_tvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.s00_axis_tready && n < 100);
      if (!bus.s00_axis_tready) begin
        timeout_fail("s00_tready");
        break;
      end
      @(posedge clk); #1;
    end
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tlast = 1'b0;
  endtask

  task automatic drain_beats(input bit toggle);
    int n;
    n = 0;
    while (exp_beats.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      bus.m00_axis_tready = toggle ? ~bus.m00_axis_tready : 1'b1;
      n++;
    end
    if (exp_beats.size() != 0) timeout_fail("stream_drain");
    @(posedge clk); #1;
    bus.m00_axis_tready = 1'b0;
  endtask

  // Every-cycle compare of BRAM writes and master-stream beats against the model.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bram_en && bram_wen) begin
          n_checks++;
          n_writes++;
          if (exp_waddr.size() == 0) begin
            n_errors++;
            $display("FAIL bram_write: unexpected write at addr %0d", bram_addr);
          end else begin
            if (bram_addr !== exp_waddr[0] || bram_in !== exp_wdata[0]) begin
              n_errors++;
              $display("FAIL bram_write: got addr %0d word0 %h word35 %h expected addr %0d word0 %h word35 %h",
                       bram_addr, bram_in[31:0], bram_in[1151:1120],
                       exp_waddr[0], exp_wdata[0][31:0], exp_wdata[0][1151:1120]);
            end
            void'(exp_waddr.pop_front());
            void'(exp_wdata.pop_front());
          end
        end
        if (bus.m00_axis_tvalid) begin
          n_checks++;
          if (prev_stall && bus.m00_axis_tdata !== prev_data) begin
            n_errors++;
            $display("FAIL stall_hold: got %h expected %h", bus.m00_axis_tdata, prev_data);
          end else if (exp_beats.size() == 0) begin
            n_errors++;
            $display("FAIL beat: unexpected beat %h", bus.m00_axis_tdata);
          end else if ({bus.m00_axis_tlast, bus.m00_axis_tdata} !== exp_beats[0]
                       || bus.m00_axis_tstrb !== 4'hF) begin
            n_errors++;
            $display("FAIL beat: got last %b data %h strb %h expected last %b data %h strb f",
                     bus.m00_axis_tlast, bus.m00_axis_tdata, bus.m00_axis_tstrb,
                     exp_beats[0][32], exp_beats[0][31:0]);
          end
          if (bus.m00_axis_tready) begin
            if (exp_beats.size() != 0) void'(exp_beats.pop_front());
            n_beats++;
            if (bus.m00_axis_tlast) n_tlasts++;
          end
        end
        prev_stall = bus.m00_axis_tvalid && !bus.m00_axis_tready;
        prev_data  = bus.m00_axis_tdata;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_status;
    int          wr0, bt0, tl0, n;
    bit          saw_ready;

    bus.s00_axis_tdata = '0; bus.s00_axis_tstrb = '0; bus.s00_axis_tlast = 1'b0;
    bus.s00_axis_tvalid = 1'b0; bus.m00_axis_tready = 1'b0;
    bus.s02_axi_awaddr = '0; bus.s02_axi_awprot = '0; bus.s02_axi_awvalid = 1'b0;
    bus.s02_axi_wdata = '0; bus.s02_axi_wstrb = '0; bus.s02_axi_wvalid = 1'b0;
    bus.s02_axi_bready = 1'b0; bus.s02_axi_araddr = '0; bus.s02_axi_arprot = '0;
    bus.s02_axi_arvalid = 1'b0; bus.s02_axi_rready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bram[i] = '0;
      mdl_mem[i] = '0;
    end
    bram_dout = '0;

    #12;
    chk("rst_axis", {29'b0, bus.s00_axis_tready, bus.m00_axis_tvalid, bus.m00_axis_tlast}, 32'd0);
    chk("rst_bram_ctl", {30'b0, bram_en, bram_wen}, 32'd0);
    chk("rst_bram_addr", {20'b0, bram_addr}, 32'd0);
    chk("rst_bram_in", {31'b0, (bram_in != '0)}, 32'd0);
    chk("rst_axil", {27'b0, bus.s02_axi_awready, bus.s02_axi_wready, bus.s02_axi_bvalid,
                     bus.s02_axi_arready, bus.s02_axi_rvalid}, 32'd0);
    chk("rst_m_tdata", bus.m00_axis_tdata, 32'd0);
    #8 rst_n = 1'b1;

    axi_read(5'h00, rd); chk("rst_reg_ctrl", rd, 32'd0);
    axi_read(5'h04, rd); chk("rst_reg_start", rd, 32'd0);
    axi_read(5'h08, rd); chk("rst_reg_end", rd, 32'd0);

    // Write session: 72 words, tlast on the last one, START=0 END=8.
    tx_data.delete(); tx_last.delete();
    for (int i = 1; i <= 72; i++) begin
      if (i == 1)                 tx_data.push_back(32'hBBBBBBBB);
      else if (i == 36 || i == 72) tx_data.push_back(32'hEEEEEEEE);
      else                        tx_data.push_back(32'h10000000 + i);
      tx_last.push_back(i == 72);
    end
    model_write(12'd0, 12'd8);
    chk("model_nwrites", exp_waddr.size(), 32'd2);
    wr0 = n_writes;
    axi_write(5'h04, 32'd0);
    axi_write(5'h08, 32'd8);
    axi_read(5'h08, rd); chk("reg_end_rb", rd, 32'd8);
    axi_write(5'h00, 32'h3);
    axi_write(5'h00, 32'h1);
    send_stream();
    repeat (5) @(negedge clk);
    chk("wr_commit_count", n_writes - wr0, 32'd2);
    chk("wr_queue_empty", exp_waddr.size(), 32'd0);
    chk("line0_w0", bram[0][31:0], 32'hBBBBBBBB);
    chk("line0_w35", bram[0][1151:1120], 32'hEEEEEEEE);
    chk("line1_w0", bram[1][31:0], 32'h10000025);
    chk("line1_w35", bram[1][1151:1120], 32'hEEEEEEEE);
    chk("done_tready", {31'b0, bus.s00_axis_tready}, 32'd0);
`ifdef AXIS_BRAM_STATUS_EN
    exp_status = 32'h00004001;
`else
    exp_status = 32'h0;
`endif
    axi_read(5'h0C, rd); chk("status_after_write", rd, exp_status);

    // Read session, sink always ready.
    model_read(12'd0, 12'd1);
    chk("model_beat0", {31'b0, exp_beats[0][32]} ^ exp_beats[0][31:0], 32'hBBBBBBBB);
    chk("model_beat71", exp_beats[71][31:0], 32'hEEEEEEEE);
    bt0 = n_beats; tl0 = n_tlasts;
    axi_write(5'h04, 32'd0);
    axi_write(5'h08, 32'd1);
    axi_write(5'h00, 32'h2);
    axi_write(5'h00, 32'h0);
    drain_beats(1'b0);
    repeat (3) @(negedge clk);
    chk("rd_beats", n_beats - bt0, 32'd72);
    chk("rd_tlasts", n_tlasts - tl0, 32'd1);

    // Read again under alternating backpressure.
    model_read(12'd0, 12'd1);
    bt0 = n_beats; tl0 = n_tlasts;
    axi_write(5'h00, 32'h2);
    axi_write(5'h00, 32'h0);
    drain_beats(1'b1);
    repeat (3) @(negedge clk);
    chk("bp_beats", n_beats - bt0, 32'd72);
    chk("bp_tlasts", n_tlasts - tl0, 32'd1);

    // Abort a partial write, then restart at START.
    axi_write(5'h04, 32'd2);
    axi_write(5'h08, 32'd3);
    axi_write(5'h00, 32'h3);
    axi_write(5'h00, 32'h1);
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < 10; i++) begin
      tx_data.push_back(32'hC0000000 + i);
      tx_last.push_back(1'b0);
    end
    wr0 = n_writes;
    send_stream();
    axi_write(5'h00, 32'h3);
    repeat (5) @(negedge clk);
    chk("abort_no_write", n_writes - wr0, 32'd0);
    tx_data.delete(); tx_last.delete();
    for (int i = 0; i < 36; i++) begin
      tx_data.push_back(32'hA0000000 + i);
      tx_last.push_back(i == 35);
    end
    model_write(12'd2, 12'd3);
    axi_write(5'h00, 32'h1);
    send_stream();
    repeat (5) @(negedge clk);
    chk("restart_writes", n_writes - wr0, 32'd1);
    chk("restart_w0", bram[2][31:0], 32'hA0000000);
    chk("restart_w35", bram[2][1151:1120], 32'hA0000023);

    // END < START: no transfer may start.
    axi_write(5'h04, 32'd5);
    axi_write(5'h08, 32'd4);
    axi_write(5'h00, 32'h3);
    axi_write(5'h00, 32'h1);
    wr0 = n_writes;
    @(posedge clk); #1;
    bus.s00_axis_tdata = 32'hDEADBEEF; bus.s00_axis_tvalid = 1'b1;
    saw_ready = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.s00_axis_tready) saw_ready = 1'b1;
      n++;
    end
    @(posedge clk); #1;
    bus.s00_axis_tvalid = 1'b0;
    chk("end_lt_start_tready", {31'b0, saw_ready}, 32'd0);
    chk("end_lt_start_writes", n_writes - wr0, 32'd0);
`ifdef AXIS_BRAM_STATUS_EN
    exp_status = 32'h00004005;
`else
    exp_status = 32'h0;
`endif
    axi_read(5'h0C, rd); chk("status_end_lt_start", rd, exp_status);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
